stream_demux2_32: RTL and testbench
===================================

STREAM_DEMUX2_32 -- requirements
Module: stream_demux2_32

Interface
REQ-001 The block SHALL use these parameters, one per line:
  WIDTH, 32, data word width.
  DEPTH, 2, per-channel buffer entries (fixed; not overridable).
  CNT_W, 16, per-channel delivered-word counter width.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset; ports, one per line:
  clk  input  1  sole clock, rising edge.
  rst  input  1  asynchronous active-high reset.
  in_data  input  32  word to steer.
  in_sel  input  1  destination: 0 selects channel 0, 1 selects channel 1.
  in_valid  input  1  in_data/in_sel valid.
  in_ready  output  1  selected channel can accept.
  out0_data  output  32  channel 0 head word.
  out0_valid  output  1  channel 0 head valid.
  out0_ready  input  1  channel 0 sink accepts.
  out1_data  output  32  channel 1 head word.
  out1_valid  output  1  channel 1 head valid.
  out1_ready  input  1  channel 1 sink accepts.
  cnt0  output  16  words delivered on channel 0.
  cnt1  output  16  words delivered on channel 1.

Function
REQ-003 Input handshake SHALL be (in_valid && in_ready) at a rising clk edge; output handshake SHALL be (outN_valid && outN_ready).
REQ-004 in_ready SHALL equal "channel in_sel occupancy < 2", computed from registered state only (no combinational path from outN_ready to in_ready).
REQ-005 An accepted word SHALL be written only to the FIFO of channel in_sel; the other channel is untouched.
REQ-006 Each channel SHALL be a 2-entry FIFO; words leave strictly in acceptance order.
REQ-007 Latency SHALL be 1 cycle: a word accepted into an empty channel appears on outN_data with outN_valid=1 in the following cycle.
REQ-008 outN_valid SHALL be 1 exactly when channel N occupancy > 0; outN_data SHALL be the head entry, held stable while outN_valid=1 and outN_ready=0.
REQ-009 Occupancy update per channel: push only +1; pop only -1; push and pop in the same cycle leaves occupancy unchanged and the head advances.
REQ-010 Full channel (occupancy 2) with pop in the same cycle SHALL NOT accept a push that cycle (in_ready was 0); the occupancy becomes 1.
REQ-011 Channels SHALL be independent: a stalled channel SHALL NOT block acceptance of words selected for the other channel.
REQ-012 Sustained throughput SHALL be one word per cycle per channel when the sink holds outN_ready=1.
REQ-013 cntN SHALL increment by 1 on each channel N output handshake and wrap from 0xFFFF to 0x0000.
REQ-014 While in_valid=0, in_sel and in_data SHALL be ignored; while in_valid=1 and not accepted, the source holds in_sel/in_data stable (bench asserts this).

Reset
REQ-015 Asserting rst SHALL immediately and asynchronously clear both occupancies, both FIFO pointers, cnt0, cnt1, out0_data, out1_data (0x00000000), out0_valid and out1_valid.
REQ-016 Reset mid-operation SHALL discard all buffered words; the first post-reset handshake occurs no earlier than the first rising edge after rst deasserts.
REQ-017 in_ready SHALL be 1 during the first cycle after reset release (both channels empty).

Structure
REQ-018 WIDTH, DEPTH and CNT_W SHALL be defined in the shared datapath constants package/header and shared with the existing 2:1 32-bit select logic.
REQ-019 Each channel SHALL be one instance of a sub-module fifo2_32 (2-entry FIFO plus delivered-word counter), instantiated twice; the top SHALL contain only steering and ready selection.

Verification
REQ-020 The bench SHALL cover these scenarios:
  Route: push 0xA0000001 (sel 0), then 0xB0000002 (sel 1), both sinks ready -> each word appears one cycle later on its own channel only; cnt0=1, cnt1=1.
  Backpressure: out0_ready=0, push 0x11, 0x22, 0x33 to channel 0 -> first two accepted, in_ready=0 for 0x33; raise out0_ready -> 0x11, 0x22, 0x33 delivered in order.
  Independence: channel 0 full and stalled, push 0x44 to channel 1 -> accepted; appears on out1 next cycle.
  Simultaneous push/pop: channel 1 occupancy 1 with out1_ready=1, push 0x55 -> occupancy stays 1, head becomes 0x55 next cycle; back-to-back streaming reaches 1 word per cycle.
  Counter wrap: 65536 deliveries on channel 0 -> cnt0 goes 0xFFFF to 0x0000.
  Reset mid-flight: both channels holding 2 words, assert rst between edges -> outN_valid=0, cnt0=cnt1=0, outN_data=0 immediately; in_ready=1 after release.

Source files
------------

// File: rtl/stream_demux2_32_pkg.sv
// ---------------------------------------------------------------------------
// stream_demux2_32_pkg
// Shared datapath constants for the 32-bit stream steering logic: word width,
// per-channel buffer depth and delivered-word counter width. The 2:1 select
// helper is the same word-select used by the existing 32-bit select logic.
// No ports (package).
// ---------------------------------------------------------------------------
package stream_demux2_32_pkg;

   localparam int WIDTH = 32;   // data word width
   localparam int DEPTH = 2;    // per-channel buffer entries (fixed)
   localparam int CNT_W = 16;   // per-channel delivered-word counter width
   localparam int OCC_W = 2;    // wide enough to hold 0..DEPTH

   localparam logic [OCC_W-1:0] OCC_EMPTY = 2'd0;
   localparam logic [OCC_W-1:0] OCC_ONE   = 2'd1;
   localparam logic [OCC_W-1:0] OCC_FULL  = 2'(DEPTH);

   // Per-cycle FIFO action, encoded as {push, pop}.
   typedef enum logic [1:0] {
      ACT_IDLE = 2'b00,
      ACT_POP  = 2'b01,
      ACT_PUSH = 2'b10,
      ACT_BOTH = 2'b11
   } fifo_act_e;

   // 2:1 word select: sel=0 returns a, sel=1 returns b.
   function automatic logic [WIDTH-1:0] mux2_32(input logic             sel,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
      logic [WIDTH-1:0] y;
      if (sel == 1'b1) begin
         y = b;
      end else begin
         y = a;
      end
      return y;
   endfunction

   // 2:1 bit select, used for picking the ready of the addressed channel.
   function automatic logic mux2_1(input logic sel,
                                   input logic a,
                                   input logic b);
      logic y;
      if (sel == 1'b1) begin
         y = b;
      end else begin
         y = a;
      end
      return y;
   endfunction

endpackage

// File: rtl/stream_demux2_32_fifo2_32.sv
// ---------------------------------------------------------------------------
// fifo2_32
// One output channel of the demux: a 2-entry first-in first-out buffer built
// as a head/tail register pair, plus a counter of words delivered to the sink.
// The head register drives the output directly, so out_data is registered
// and stays stable while the sink stalls.
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous active-high reset
//   push       in   1      write wr_data this cycle (caller guarantees !full)
//   wr_data    in   32     word to buffer
//   full       out  1      buffer holds 2 words (registered)
//   out_data   out  32     head word (registered)
//   out_valid  out  1      head word valid (registered)
//   out_ready  in   1      sink accepts head word
//   cnt        out  16     words delivered, wraps at 0xFFFF
// ---------------------------------------------------------------------------
module fifo2_32
   import stream_demux2_32_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   output logic             full,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] cnt
);

   logic [OCC_W-1:0] occ_r;
   logic [WIDTH-1:0] head_r;
   logic [WIDTH-1:0] tail_r;
   logic             valid_r;
   logic             full_r;
   logic [CNT_W-1:0] cnt_r;

   logic             pop_s;
   fifo_act_e        act_s;
   logic [OCC_W-1:0] occ_s;
   logic [WIDTH-1:0] head_s;
   logic [WIDTH-1:0] tail_s;

   // Next-state of occupancy and the head/tail entries for this cycle's action.
   always_comb begin
      pop_s  = valid_r & out_ready;
      act_s  = fifo_act_e'({push, pop_s});
      occ_s  = occ_r;
      head_s = head_r;
      tail_s = tail_r;
      case (act_s)
         ACT_PUSH: begin
            if (occ_r == OCC_EMPTY) begin
               head_s = wr_data;
               occ_s  = OCC_ONE;
            end else if (occ_r == OCC_ONE) begin
               tail_s = wr_data;
               occ_s  = OCC_FULL;
            end else begin
               // Push into a full buffer is never requested; drop it safely.
               occ_s  = occ_r;
            end
         end
         ACT_POP: begin
            if (occ_r == OCC_FULL) begin
               // Second word moves up to become the new head.
               head_s = tail_r;
               occ_s  = OCC_ONE;
            end else if (occ_r == OCC_ONE) begin
               // Head keeps its stale value; out_valid drops instead.
               occ_s  = OCC_EMPTY;
            end else begin
               occ_s  = occ_r;
            end
         end
         ACT_BOTH: begin
            if (occ_r == OCC_ONE) begin
               // Head leaves and the incoming word replaces it directly.
               head_s = wr_data;
            end else begin
               // Only reachable when full: shift tail up, refill tail.
               head_s = tail_r;
               tail_s = wr_data;
            end
            occ_s = occ_r;
         end
         ACT_IDLE: begin
            occ_s = occ_r;
         end
         default: begin
            occ_s = occ_r;
         end
      endcase
   end

   // Buffer state and registered status flags, cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occ_r   <= OCC_EMPTY;
         head_r  <= 32'h0000_0000;
         tail_r  <= 32'h0000_0000;
         valid_r <= 1'b0;
         full_r  <= 1'b0;
      end else begin
         occ_r   <= occ_s;
         head_r  <= head_s;
         tail_r  <= tail_s;
         valid_r <= (occ_s != OCC_EMPTY);
         full_r  <= (occ_s == OCC_FULL);
      end
   end

   // Delivered-word counter; wraps naturally at its width.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r <= 16'h0000;
      end else if (pop_s) begin
         cnt_r <= cnt_r + 16'h0001;
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign full      = full_r;
   assign out_data  = head_r;
   assign out_valid = valid_r;
   assign cnt       = cnt_r;

endmodule

// File: rtl/stream_demux2_32.sv
// ---------------------------------------------------------------------------
// stream_demux2_32
// 1-to-2 stream demultiplexer. Each input word is steered by in_sel into one
// of two independent 2-entry channels; a stalled channel never blocks the
// other. in_ready depends only on registered channel state and in_sel, so
// there is no combinational path from the sinks' ready back to the source.
// Ports:
//   clk         in   1    rising-edge clock
//   rst         in   1    asynchronous active-high reset
//   in_data     in   32   word to steer
//   in_sel      in   1    0 = channel 0, 1 = channel 1
//   in_valid    in   1    in_data/in_sel valid
//   in_ready    out  1    selected channel can accept
//   out0_data   out  32   channel 0 head word
//   out0_valid  out  1    channel 0 head valid
//   out0_ready  in   1    channel 0 sink accepts
//   out1_data   out  32   channel 1 head word
//   out1_valid  out  1    channel 1 head valid
//   out1_ready  in   1    channel 1 sink accepts
//   cnt0        out  16   words delivered on channel 0
//   cnt1        out  16   words delivered on channel 1
// ---------------------------------------------------------------------------
module stream_demux2_32
   import stream_demux2_32_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_sel,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out0_data,
   output logic             out0_valid,
   input  logic             out0_ready,
   output logic [WIDTH-1:0] out1_data,
   output logic             out1_valid,
   input  logic             out1_ready,
   output logic [CNT_W-1:0] cnt0,
   output logic [CNT_W-1:0] cnt1
);

   logic full0_s;
   logic full1_s;
   logic ready_s;
   logic accept_s;
   logic push0_s;
   logic push1_s;

   // Ready of the addressed channel and steering of the accepted word.
   always_comb begin
      ready_s  = mux2_1(in_sel, ~full0_s, ~full1_s);
      accept_s = in_valid & ready_s;
      if (accept_s) begin
         push0_s = ~in_sel;
         push1_s = in_sel;
      end else begin
         push0_s = 1'b0;
         push1_s = 1'b0;
      end
   end

   assign in_ready = ready_s;

   fifo2_32 u_ch0 (
      .clk       (clk),
      .rst       (rst),
      .push      (push0_s),
      .wr_data   (in_data),
      .full      (full0_s),
      .out_data  (out0_data),
      .out_valid (out0_valid),
      .out_ready (out0_ready),
      .cnt       (cnt0)
   );

   fifo2_32 u_ch1 (
      .clk       (clk),
      .rst       (rst),
      .push      (push1_s),
      .wr_data   (in_data),
      .full      (full1_s),
      .out_data  (out1_data),
      .out_valid (out1_valid),
      .out_ready (out1_ready),
      .cnt       (cnt1)
   );

endmodule

// File: tb/tb_stream_demux2_32.sv
// ---------------------------------------------------------------------------
// tb_stream_demux2_32
// Directed bench for stream_demux2_32: routing, backpressure, channel
// independence, simultaneous push/pop, counter wrap and mid-flight reset.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_stream_demux2_32;

   logic        clk;
   logic        rst;
   logic [31:0] in_data;
   logic        in_sel;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] out0_data;
   logic        out0_valid;
   logic        out0_ready;
   logic [31:0] out1_data;
   logic        out1_valid;
   logic        out1_ready;
   logic [15:0] cnt0;
   logic [15:0] cnt1;

   int n_checks = 0;
   int n_fail   = 0;

   stream_demux2_32 dut (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data),
      .in_sel     (in_sel),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out0_data  (out0_data),
      .out0_valid (out0_valid),
      .out0_ready (out0_ready),
      .out1_data  (out1_data),
      .out1_valid (out1_valid),
      .out1_ready (out1_ready),
      .cnt0       (cnt0),
      .cnt1       (cnt1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      rst        = 1'b1;
      in_data    = 32'h0;
      in_sel     = 1'b0;
      in_valid   = 1'b0;
      out0_ready = 1'b0;
      out1_ready = 1'b0;
      #1;
      // Reset state
      check("rst_v0",   {31'd0, out0_valid}, 32'd0);
      check("rst_v1",   {31'd0, out1_valid}, 32'd0);
      check("rst_d0",   out0_data, 32'h0);
      check("rst_d1",   out1_data, 32'h0);
      check("rst_c0",   {16'd0, cnt0}, 32'd0);
      check("rst_c1",   {16'd0, cnt1}, 32'd0);
      tick();
      tick();
      rst = 1'b0;
      check("rdy_after_rel_s0", {31'd0, in_ready}, 32'd1);
      in_sel = 1'b1;
      #1;
      check("rdy_after_rel_s1", {31'd0, in_ready}, 32'd1);

      // Route
      out0_ready = 1'b1;
      out1_ready = 1'b1;
      in_valid   = 1'b1;
      in_sel     = 1'b0;
      in_data    = 32'hA000_0001;
      #1;
      check("route_rdy0", {31'd0, in_ready}, 32'd1);
      tick();
      check("route_v0",  {31'd0, out0_valid}, 32'd1);
      check("route_d0",  out0_data, 32'hA000_0001);
      check("route_nv1", {31'd0, out1_valid}, 32'd0);
      in_sel  = 1'b1;
      in_data = 32'hB000_0002;
      tick();
      check("route_v1",  {31'd0, out1_valid}, 32'd1);
      check("route_d1",  out1_data, 32'hB000_0002);
      check("route_nv0", {31'd0, out0_valid}, 32'd0);
      check("route_c0",  {16'd0, cnt0}, 32'd1);
      in_valid = 1'b0;
      tick();
      check("route_c1",  {16'd0, cnt1}, 32'd1);
      check("route_e1",  {31'd0, out1_valid}, 32'd0);

      // Backpressure on channel 0
      out0_ready = 1'b0;
      in_valid   = 1'b1;
      in_sel     = 1'b0;
      in_data    = 32'h11;
      tick();
      in_data = 32'h22;
      #1;
      check("bp_rdy_2nd", {31'd0, in_ready}, 32'd1);
      tick();
      in_data = 32'h33;
      #1;
      check("bp_rdy_full", {31'd0, in_ready}, 32'd0);
      check("bp_head",     out0_data, 32'h11);
      tick();
      check("bp_hold",     out0_data, 32'h11);
      check("bp_still_full", {31'd0, in_ready}, 32'd0);

      // Independence: channel 0 full and stalled, channel 1 accepts
      in_valid = 1'b0;
      tick();
      in_valid = 1'b1;
      in_sel   = 1'b1;
      in_data  = 32'h44;
      #1;
      check("ind_rdy1", {31'd0, in_ready}, 32'd1);
      tick();
      check("ind_v1", {31'd0, out1_valid}, 32'd1);
      check("ind_d1", out1_data, 32'h44);
      check("ind_hold0", out0_data, 32'h11);

      // Release channel 0: full with pop does not accept 0x33 this cycle
      in_sel     = 1'b0;
      in_data    = 32'h33;
      out0_ready = 1'b1;
      #1;
      check("bp_pop_full_rdy", {31'd0, in_ready}, 32'd0);
      tick();
      check("bp_d22",  out0_data, 32'h22);
      check("bp_rdy1", {31'd0, in_ready}, 32'd1);
      check("ind_c1",  {16'd0, cnt1}, 32'd2);
      check("bp_c0a",  {16'd0, cnt0}, 32'd2);
      tick();
      in_valid = 1'b0;
      check("bp_d33",  out0_data, 32'h33);
      check("bp_c0b",  {16'd0, cnt0}, 32'd3);
      tick();
      check("bp_c0c",  {16'd0, cnt0}, 32'd4);
      check("bp_empty", {31'd0, out0_valid}, 32'd0);

      // Simultaneous push/pop on channel 1
      out1_ready = 1'b0;
      in_valid   = 1'b1;
      in_sel     = 1'b1;
      in_data    = 32'h50;
      tick();
      check("pp_head50", out1_data, 32'h50);
      out1_ready = 1'b1;
      in_data    = 32'h55;
      #1;
      check("pp_rdy", {31'd0, in_ready}, 32'd1);
      tick();
      check("pp_head55", out1_data, 32'h55);
      check("pp_v",      {31'd0, out1_valid}, 32'd1);
      check("pp_rdy_occ1", {31'd0, in_ready}, 32'd1);
      check("pp_c1",     {16'd0, cnt1}, 32'd3);
      for (int k = 0; k < 3; k++) begin
         in_data = 32'h56 + 32'(k);
         tick();
         check("stream_d", out1_data, 32'h56 + 32'(k));
         check("stream_c", {16'd0, cnt1}, 32'd4 + 32'(k));
      end
      in_valid = 1'b0;
      tick();
      check("stream_end_c", {16'd0, cnt1}, 32'd7);
      check("stream_end_v", {31'd0, out1_valid}, 32'd0);

      // Reset mid-flight with both channels full
      out0_ready = 1'b0;
      out1_ready = 1'b0;
      in_valid   = 1'b1;
      in_sel     = 1'b0;
      in_data    = 32'h70;
      tick();
      in_data = 32'h71;
      tick();
      in_sel  = 1'b1;
      in_data = 32'h80;
      tick();
      in_data = 32'h81;
      tick();
      in_valid = 1'b0;
      check("mf_full1", {31'd0, in_ready}, 32'd0);
      check("mf_v0",    {31'd0, out0_valid}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("mf_v0_clr", {31'd0, out0_valid}, 32'd0);
      check("mf_v1_clr", {31'd0, out1_valid}, 32'd0);
      check("mf_d0_clr", out0_data, 32'h0);
      check("mf_d1_clr", out1_data, 32'h0);
      check("mf_c0_clr", {16'd0, cnt0}, 32'd0);
      check("mf_c1_clr", {16'd0, cnt1}, 32'd0);
      tick();
      rst        = 1'b0;
      out0_ready = 1'b1;
      out1_ready = 1'b1;
      in_sel     = 1'b0;
      #1;
      check("mf_rdy0", {31'd0, in_ready}, 32'd1);
      in_sel = 1'b1;
      #1;
      check("mf_rdy1", {31'd0, in_ready}, 32'd1);
      tick();
      check("mf_nov0", {31'd0, out0_valid}, 32'd0);
      check("mf_nov1", {31'd0, out1_valid}, 32'd0);

      // Counter wrap on channel 0: 65536 deliveries
      in_valid = 1'b1;
      in_sel   = 1'b0;
      for (int i = 0; i < 65535; i++) begin
         in_data = 32'(i);
         tick();
         if (i == 1000) begin
            check("wrap_mid_d", out0_data, 32'd1000);
            check("wrap_mid_c", {16'd0, cnt0}, 32'd1000);
         end
      end
      check("wrap_pre_c", {16'd0, cnt0}, 32'd65534);
      in_valid = 1'b0;
      tick();
      check("wrap_ffff", {16'd0, cnt0}, 32'h0000_FFFF);
      in_valid = 1'b1;
      in_data  = 32'hDEAD_BEEF;
      tick();
      in_valid = 1'b0;
      check("wrap_last_d", out0_data, 32'hDEAD_BEEF);
      check("wrap_hold",   {16'd0, cnt0}, 32'h0000_FFFF);
      tick();
      check("wrap_zero",   {16'd0, cnt0}, 32'h0000_0000);
      check("wrap_c1",     {16'd0, cnt1}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
